// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_buffer
// Description : Circular capture buffer for retired RV32 instructions. Once
//               armed, every commit (PC, instruction word, rd, writeback data)
//               is stored. The buffer overwrites the oldest entry when full.
//               A PC-match trigger freezes capture after a programmable
//               number of further commits. The frozen trace is drained
//               oldest-first through a pop interface.
// Ports       : clk, rst (async, active-high)
//               commit_valid/pc/instr/rd/wdata : retire snoop
//               arm, stop                      : capture control
//               trig_en, trig_pc, post_count   : trigger setup
//               rd_en -> rd_valid, rd_pc/instr/rd/wdata : drain port
//               state, count, overflow         : status
// Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 16,
  parameter int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_valid,
  input  logic [PC_WIDTH-1:0]   commit_pc,
  input  logic [31:0]           commit_instr,
  input  logic [4:0]            commit_rd,
  input  logic [DATA_WIDTH-1:0] commit_wdata,
  input  logic                  arm,
  input  logic                  stop,
  input  logic                  trig_en,
  input  logic [PC_WIDTH-1:0]   trig_pc,
  input  logic [CW-1:0]         post_count,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [PC_WIDTH-1:0]   rd_pc,
  output logic [31:0]           rd_instr,
  output logic [4:0]            rd_rd,
  output logic [DATA_WIDTH-1:0] rd_wdata,
  output logic [1:0]            state,
  output logic [CW-1:0]         count,
  output logic                  overflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_armed = 2'd1;
  localparam logic [1:0] c_st_trig  = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic [CW-1:0] c_full     = CW'(DEPTH);
  localparam logic [CW-1:0] c_max_post = CW'(DEPTH - 1);
  localparam logic [CW-1:0] c_one      = CW'(1);
  localparam logic [AW-1:0] c_ptr_one  = AW'(1);

  // Entry storage; deliberately never cleared so it maps onto plain RAM.
  logic [PC_WIDTH-1:0]   mem_pc_q    [DEPTH];
  logic [31:0]           mem_instr_q [DEPTH];
  logic [4:0]            mem_rd_q    [DEPTH];
  logic [DATA_WIDTH-1:0] mem_wdata_q [DEPTH];

  logic [1:0]    state_q,  state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [CW-1:0] rem_q,    rem_d;
  logic          ovf_q,    ovf_d;

  logic          w_wr_en;
  logic          w_trig_hit;
  logic [CW-1:0] w_post_clamped;

  assign w_trig_hit = commit_valid && trig_en && (commit_pc == trig_pc);

  // Clamp so the trigger entry itself can never be overwritten.
  assign w_post_clamped = (post_count > c_max_post) ? c_max_post : post_count;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;
    w_wr_en  = 1'b0;

    if (arm) begin
      // Re-arm wins over everything; a same-cycle commit is dropped.
      state_d  = c_st_armed;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      rem_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        c_st_armed, c_st_trig: begin
          if (commit_valid) begin
            w_wr_en  = 1'b1;
            wr_ptr_d = wr_ptr_q + c_ptr_one;
            if (count_q == c_full) begin
              // Full: the write lands on the oldest slot, so drop it.
              rd_ptr_d = rd_ptr_q + c_ptr_one;
              ovf_d    = 1'b1;
            end else begin
              count_d = count_q + c_one;
            end
          end

          if (stop) begin
            state_d = c_st_done;
          end else if ((state_q == c_st_armed) && w_trig_hit) begin
            rem_d   = w_post_clamped;
            state_d = (w_post_clamped == '0) ? c_st_done : c_st_trig;
          end else if ((state_q == c_st_trig) && commit_valid) begin
            rem_d = rem_q - c_one;
            if (rem_q == c_one) begin
              state_d = c_st_done;
            end
          end
        end

        c_st_done: begin
          if (rd_en && (count_q != '0)) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
            count_d  = count_q - c_one;
          end
        end

        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= c_st_idle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_pc_q[wr_ptr_q]    <= commit_pc;
      mem_instr_q[wr_ptr_q] <= commit_instr;
      mem_rd_q[wr_ptr_q]    <= commit_rd;
      mem_wdata_q[wr_ptr_q] <= commit_wdata;
    end
  end

  // Zero-latency read of the oldest entry, gated so idle outputs read as 0.
  assign rd_valid = (state_q == c_st_done) && (count_q != '0);
  assign rd_pc    = rd_valid ? mem_pc_q[rd_ptr_q]    : '0;
  assign rd_instr = rd_valid ? mem_instr_q[rd_ptr_q] : '0;
  assign rd_rd    = rd_valid ? mem_rd_q[rd_ptr_q]    : '0;
  assign rd_wdata = rd_valid ? mem_wdata_q[rd_ptr_q] : '0;

  assign state    = state_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_trace_buffer
// Description : Self-checking bench for commit_trace_buffer. A queue-based
//               reference model tracks the captured trace; every cycle all
//               outputs are compared against it. Directed scenarios also
//               check fixed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          commit_valid = 1'b0;
  logic [31:0]   commit_pc = '0;
  logic [31:0]   commit_instr = '0;
  logic [4:0]    commit_rd = '0;
  logic [31:0]   commit_wdata = '0;
  logic          arm = 1'b0;
  logic          stop = 1'b0;
  logic          trig_en = 1'b0;
  logic [31:0]   trig_pc = '0;
  logic [CW-1:0] post_count = '0;
  logic          rd_en = 1'b0;
  logic          rd_valid;
  logic [31:0]   rd_pc;
  logic [31:0]   rd_instr;
  logic [4:0]    rd_rd;
  logic [31:0]   rd_wdata;
  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          overflow;

  commit_trace_buffer #(
    .DATA_WIDTH(32),
    .PC_WIDTH  (32),
    .DEPTH     (DEPTH)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .commit_valid(commit_valid),
    .commit_pc   (commit_pc),
    .commit_instr(commit_instr),
    .commit_rd   (commit_rd),
    .commit_wdata(commit_wdata),
    .arm         (arm),
    .stop        (stop),
    .trig_en     (trig_en),
    .trig_pc     (trig_pc),
    .post_count  (post_count),
    .rd_en       (rd_en),
    .rd_valid    (rd_valid),
    .rd_pc       (rd_pc),
    .rd_instr    (rd_instr),
    .rd_rd       (rd_rd),
    .rd_wdata    (rd_wdata),
    .state       (state),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } ent_t;

  // Reference model: trace as a queue, oldest at the front.
  ent_t m_q[$];
  int   m_state;
  bit   m_ovf;
  int   m_rem;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state = 0;
    m_ovf   = 1'b0;
    m_rem   = 0;
  endtask

  task automatic model_step();
    ent_t e;
    int   p;
    if (rst) begin
      model_reset();
    end else if (arm) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_rem   = 0;
      m_state = 1;
    end else if (m_state == 1 || m_state == 2) begin
      if (commit_valid) begin
        e.pc = commit_pc; e.instr = commit_instr; e.rd = commit_rd; e.wdata = commit_wdata;
        m_q.push_back(e);
        if (m_q.size() > DEPTH) begin
          void'(m_q.pop_front());
          m_ovf = 1'b1;
        end
      end
      if (stop) begin
        m_state = 3;
      end else if (m_state == 1 && commit_valid && trig_en && commit_pc == trig_pc) begin
        p       = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
        m_rem   = p;
        m_state = (p == 0) ? 3 : 2;
      end else if (m_state == 2 && commit_valid) begin
        m_rem--;
        if (m_rem == 0) m_state = 3;
      end
    end else if (m_state == 3) begin
      if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
    end
  endtask

  task automatic check_all();
    bit   v;
    ent_t e;
    v = (m_state == 3) && (m_q.size() > 0);
    if (v) e = m_q[0];
    else begin
      e.pc = '0; e.instr = '0; e.rd = '0; e.wdata = '0;
    end
    chk("state",    64'(state),    64'(m_state));
    chk("count",    64'(count),    64'(m_q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("rd_valid", 64'(rd_valid), 64'(v));
    chk("rd_pc",    64'(rd_pc),    64'(e.pc));
    chk("rd_instr", 64'(rd_instr), 64'(e.instr));
    chk("rd_rd",    64'(rd_rd),    64'(e.rd));
    chk("rd_wdata", 64'(rd_wdata), 64'(e.wdata));
  endtask

  // One clock: drive inputs, update model on the edge, check 1 time unit later.
  task automatic cyc(input bit cv, input logic [31:0] pc, input bit a, input bit s, input bit r);
    commit_valid = cv;
    commit_pc    = pc;
    commit_instr = $urandom;
    commit_rd    = 5'($urandom);
    commit_wdata = $urandom;
    arm          = a;
    stop         = s;
    rd_en        = r;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drain_expect_last(input string tag, input logic [31:0] last_pc);
    int n;
    n = int'(count);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) chk(tag, 64'(rd_pc), 64'(last_pc));
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    end
    chk({tag, "_empty"}, 64'(rd_valid), 64'd0);
  endtask

  task automatic trig_run(input logic [CW-1:0] post, input bit gaps);
    trig_en    = 1'b1;
    trig_pc    = 32'h40;
    post_count = post;
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'(4 * k), 1'b0, 1'b0, 1'b0);
    end
    chk("trig_done", 64'(state), 64'd3);
  endtask

  initial begin
    model_reset();

    // Reset held while commits stream.
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'(4 * k), 1'b0, 1'b0, 1'b0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'(4 * k), 1'b0, 1'b0, 1'b0);
    chk("idle_count", 64'(count), 64'd0);

    // Basic capture, stop and drain.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 32'(4 * k), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("basic_state", 64'(state), 64'd3);
    chk("basic_count", 64'(count), 64'd5);
    for (int k = 0; k < 5; k++) begin
      chk("basic_pc", 64'(rd_pc), 64'(4 * k));
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    end
    chk("basic_empty", 64'(rd_valid), 64'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);  // pop on empty: no effect

    // Wrap / overflow.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) cyc(1'b1, 32'h100 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("wrap_count", 64'(count), 64'd16);
    chk("wrap_ovf",   64'(overflow), 64'd1);
    chk("wrap_first", 64'(rd_pc), 64'h110);
    drain_expect_last("wrap_last", 32'h14C);

    // Trigger window, with and without idle gaps.
    trig_run(CW'(3), 1'b0);
    chk("win_count", 64'(count), 64'd16);
    chk("win_first", 64'(rd_pc), 64'h10);
    drain_expect_last("win_last", 32'h4C);
    trig_run(CW'(3), 1'b1);
    chk("gap_first", 64'(rd_pc), 64'h10);
    drain_expect_last("gap_last", 32'h4C);

    // Clamp and post_count 0.
    trig_run(CW'(20), 1'b0);
    chk("clamp_first", 64'(rd_pc), 64'h40);
    drain_expect_last("clamp_last", 32'h7C);
    trig_run(CW'(0), 1'b0);
    drain_expect_last("post0_last", 32'h40);

    // Arm plus commit while DONE.
    cyc(1'b1, 32'h999, 1'b1, 1'b0, 1'b0);
    chk("armc_count", 64'(count), 64'd0);
    chk("armc_state", 64'(state), 64'd1);
    chk("armc_ovf",   64'(overflow), 64'd0);

    // Stop plus commit: the commit is kept.
    trig_en = 1'b0;
    cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h204, 1'b0, 1'b1, 1'b0);
    chk("stopc_count", 64'(count), 64'd2);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("stopc_pc", 64'(rd_pc), 64'h204);

    // Reset pulse mid-drain.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b1, 32'(4 * k), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rstd_state", 64'(state), 64'd0);
    chk("rstd_count", 64'(count), 64'd0);
    chk("rstd_valid", 64'(rd_valid), 64'd0);
    chk("rstd_pc",    64'(rd_pc), 64'd0);
    check_all();
    cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        trig_en    = 1'($urandom);
        trig_pc    = 32'h40;
        post_count = CW'($urandom_range(0, 31));
      end
      cyc(1'($urandom_range(0, 3) != 0),
          32'(4 * $urandom_range(0, 31)),
          $urandom_range(0, 49) == 0,
          $urandom_range(0, 59) == 0,
          1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Synthesizable, parametrised commit-trace capture block for the RV32 core. It sits beside `top`, snoops each retired instruction (PC, instruction word, destination register, writeback data) into a circular buffer, and freezes on a PC-match trigger after a programmable number of post-trigger commits. The frozen trace is then drained through a pop interface. This replaces per-cycle register dumps in benches and gives silicon-style post-mortem visibility.

## Interface
- `DATA_WIDTH`, 32: width of writeback data.
- `PC_WIDTH`, 32: width of PC and trigger address.
- `DEPTH`, 16: buffer entries; power of two, ≥ 2.
- `CW`, $clog2(DEPTH)+1: count/post-count width (derived, not overridden).

Ports (reset is asynchronous and active-high):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `commit_valid` in 1: one instruction retires this cycle.
- `commit_pc` in PC_WIDTH: PC of the retiring instruction.
- `commit_instr` in 32: instruction word.
- `commit_rd` in 5: destination register index (0 if none).
- `commit_wdata` in DATA_WIDTH: writeback value.
- `arm` in 1: clear the buffer and start capture.
- `stop` in 1: force freeze.
- `trig_en` in 1: enable the PC-match trigger.
- `trig_pc` in PC_WIDTH: trigger address.
- `post_count` in CW: commits captured after the trigger commit.
- `rd_en` in 1: pop the oldest entry.
- `rd_valid` out 1: rd_* outputs hold a valid entry.
- `rd_pc`, `rd_instr`, `rd_rd`, `rd_wdata` out (matching widths): oldest entry.
- `state` out 2: IDLE=0, ARMED=1, TRIGGERED=2, DONE=3.
- `count` out CW: entries held (0..DEPTH).
- `overflow` out 1: sticky; set when an entry has been overwritten since the last arm.

## Operation
- IDLE: no capture. `rd_en` is ignored.
- ARMED: every `commit_valid` writes one entry at `wr_ptr`.
  - If `count`==DEPTH, the write overwrites the oldest entry, `rd_ptr` advances, `count` holds at DEPTH and `overflow` is set.
  - Otherwise `count` increments.
- Trigger: in ARMED, `commit_valid && trig_en && commit_pc==trig_pc`.
  - The triggering commit is written.
  - `post_count` is sampled on that cycle and clamped to DEPTH-1, so the trigger entry always survives.
  - Sampled value 0: go to DONE. Otherwise go to TRIGGERED with `remaining` = sampled value.
- TRIGGERED: each commit is written (same overwrite rules) and `remaining` decrements. The commit that takes `remaining` from 1 to 0 moves the state to DONE.
- DONE: capture is frozen and commits are ignored.
  - `rd_valid` = (`count`≠0).
  - `rd_en && rd_valid` pops: `rd_ptr`+1 mod DEPTH, `count`-1.
  - `rd_en` with `count`=0 has no effect.
- `stop` in ARMED or TRIGGERED: go to DONE. A commit in the same cycle is still written.
- `arm` from any state: clear `wr_ptr`, `rd_ptr`, `count`, `remaining` and `overflow`, then go to ARMED. A commit in the same cycle is not captured.
- Priority: `arm` > `stop` > trigger > normal capture.
- Pointers wrap modulo DEPTH. Memory contents are not cleared by arm or reset.
- `rd_valid`=0 forces all rd_* outputs to 0.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `count` 0, `overflow` 0, pointers 0, `remaining` 0, `rd_valid` 0, rd_* 0.
- All state, pointer, count and memory updates occur on the rising `clk` edge.
- Read path is combinational from the memory at `rd_ptr`. An entry popped at edge N exposes the next entry immediately after edge N (zero-cycle read latency).
- Capture latency: a commit at edge N is counted in `count` after edge N.
- Trigger to DONE:
  - `post_count`=0: DONE after the trigger edge.
  - Otherwise: DONE after the edge of the `post_count`-th later commit. Cycles without `commit_valid` do not count.
- A trigger match while in TRIGGERED or DONE is ignored (no re-trigger).
- `rst` asserted mid-capture or mid-drain aborts immediately to reset values.

## Test plan
- Reset: hold `rst` while commits stream -> `state`=0, `count`=0, `rd_valid`=0, `overflow`=0. After release with no `arm`, commits still leave `count`=0.
- Basic capture and stop (DEPTH=16):
  - `arm`, then 5 commits with PC 0x00..0x10, then `stop` -> `state`=3, `count`=5.
  - Drain with `rd_en` held -> `rd_pc` sequence 0x00,0x04,0x08,0x0C,0x10, then `rd_valid`=0.
- Wrap/overflow: `arm`, 20 commits with PC 0x100+4k, then `stop` -> `count`=16, `overflow`=1, first `rd_pc`=0x110, last `rd_pc`=0x14C.
- Trigger window: `trig_en`=1, `trig_pc`=0x40, `post_count`=3, commits at PC 0x00..0x7C -> DONE after the commit at 0x4C.
  - Buffer holds 0x10..0x4C (16 entries).
  - Idle gaps between commits do not shorten the window.
- Clamp and post 0:
  - `post_count`=20 -> behaves as 15; the trigger entry is the first entry read.
  - `post_count`=0 -> DONE on the trigger edge; the last entry read is the trigger PC.
- Simultaneous events:
  - `arm` and commit on the same cycle in DONE -> `count`=0, `overflow`=0, `state`=1.
  - `stop` and commit on the same cycle -> the commit is captured.
  - `rst` pulse mid-drain -> all outputs return to reset values.
